// File: rtl/mpadder_pkg.sv
// Shared types and sizing helpers for the sequential multi-precision adder.
package mpadder_pkg;

   localparam int unsigned DEF_OP_W    = 1027;
   localparam int unsigned DEF_CHUNK_W = 128;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Number of CHUNK_W slices needed to cover an operand.
   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/mp_chunk_add.sv
// Combinational W-bit adder slice with carry-in and carry-out.
module mp_chunk_add #(
   parameter int unsigned W = 128
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum_c,
   output logic         cout_c
);

   localparam int unsigned SW = W + 1;

   assign {cout_c, sum_c} = SW'(a) + SW'(b) + SW'(cin);

endmodule

// File: rtl/mpadder_seq.sv
// Sequential wide add/subtract: one CHUNK_W slice per cycle through a single
// carry-propagating adder; result MSB is carry-out (add) or A<B flag (subtract).
module mpadder_seq
   import mpadder_pkg::*;
#(
   parameter int unsigned OP_W    = DEF_OP_W,
   parameter int unsigned CHUNK_W = DEF_CHUNK_W
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            subtract,
   input  logic [OP_W-1:0] in_a,
   input  logic [OP_W-1:0] in_b,
   output logic [OP_W:0]   result,
   output logic            busy,
   output logic            done
);

   localparam int unsigned NCHUNK  = ceil_div(OP_W, CHUNK_W);
   localparam int unsigned PAD_W   = NCHUNK * CHUNK_W;
   localparam int unsigned CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned LAST_LO = (NCHUNK - 1) * CHUNK_W;
   localparam int unsigned LAST_W  = OP_W - LAST_LO;
   localparam int unsigned AIDX_W  = (PAD_W > 1) ? $clog2(PAD_W) : 1;
   localparam int unsigned RIDX_W  = $clog2(OP_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

   state_e             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               sub_q, sub_d;
   logic [PAD_W-1:0]   a_q, a_d;
   logic [PAD_W-1:0]   b_q, b_d;
   logic [OP_W:0]      res_q, res_d;

   logic [AIDX_W-1:0]  a_base;
   logic [RIDX_W-1:0]  res_base;
   logic [CHUNK_W-1:0] add_sum;
   logic               add_cout;
   logic               top_bit;

   assign a_base   = AIDX_W'(32'(cnt_q) * CHUNK_W);
   assign res_base = RIDX_W'(32'(cnt_q) * CHUNK_W);

   mp_chunk_add #(
      .W(CHUNK_W)
   ) u_chunk_add (
      .a      (a_q[a_base +: CHUNK_W]),
      .b      (b_q[a_base +: CHUNK_W]),
      .cin    (carry_q),
      .sum_c  (add_sum),
      .cout_c (add_cout)
   );

   // Bit OP_W of the padded sum: carry-out when OP_W fills the last chunk, else a sum bit.
   if (LAST_W == CHUNK_W) begin : g_full_last
      assign top_bit = add_cout;
   end else begin : g_part_last
      assign top_bit = add_sum[LAST_W];
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = PAD_W'(in_a);
               b_d     = PAD_W'(in_b ^ {OP_W{subtract}});
               sub_d   = subtract;
               carry_d = subtract;
               cnt_d   = '0;
               state_d = ST_RUN;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            carry_d = add_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               // Subtract inverts the carry so the MSB reads as a borrow (A < B).
               res_d[OP_W:LAST_LO] = {top_bit ^ sub_q, add_sum[LAST_W-1:0]};
               cnt_d   = '0;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               res_d[res_base +: CHUNK_W] = add_sum;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Control and result registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         res_q   <= res_d;
      end
   end

   // Operand registers carry no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign result = res_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
